// File: rtl/branch_cond_unit.sv
// Branch-condition unit: one-beat single-operand tests, two-beat operand compares.
// Optional feature macro: BRANCH_COND_UNSIGNED_EN (unsigned brlt/brge via ir_in[COND_LSB+3]).
module branch_cond_unit #(
   parameter int WIDTH    = 32,
   parameter int IR_WIDTH = 32,
   parameter int COND_LSB = 19
) (
   input  logic                clock,
   input  logic                clear_n,
   input  logic                con_in,
   input  logic [IR_WIDTH-1:0] ir_in,
   input  logic [WIDTH-1:0]    bus_in,
   input  logic                b_valid,
   input  logic                flush,
   output logic                con_out,
   output logic                busy,
   output logic                done
);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_WAIT_B = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_con_out;
   logic             r_done;
   logic [2:0]       r_cond_q;
   logic [WIDTH-1:0] r_a_q;
   logic             w_con_nxt;
   logic             w_done_nxt;
   logic             w_load;
   logic [2:0]       w_cond;
   logic             w_u_cur;
   logic             w_u_held;

   assign w_cond = ir_in[COND_LSB+2:COND_LSB];

`ifdef BRANCH_COND_UNSIGNED_EN
   logic r_u_q;
   assign w_u_cur  = ir_in[COND_LSB+3];
   assign w_u_held = r_u_q;

   // Unsigned-select bit travels with the latched condition code
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         r_u_q <= 1'b0;
      end else if (w_load) begin
         r_u_q <= w_u_cur;
      end else begin
         r_u_q <= r_u_q;
      end
   end
`else
   assign w_u_cur  = 1'b0;
   assign w_u_held = 1'b0;
`endif

   function automatic logic f_eval(input logic [2:0] cond, input logic u,
                                   input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic res;
      res = 1'b0;
      case (cond)
         3'b000:  res = (a == {WIDTH{1'b0}});
         3'b001:  res = (a != {WIDTH{1'b0}});
         3'b010:  res = (a[WIDTH-1] == 1'b0);
         3'b011:  res = (a[WIDTH-1] == 1'b1);
         3'b100:  res = (a == b);
         3'b101:  res = (a != b);
         3'b110:  res = u ? (a < b)  : ($signed(a) <  $signed(b));
         3'b111:  res = u ? (a >= b) : ($signed(a) >= $signed(b));
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   // Next-state and decision logic; cond_q/a_q isolate WAIT_B from ir_in changes
   always_comb begin
      w_state_nxt = r_state;
      w_con_nxt   = r_con_out;
      w_done_nxt  = 1'b0;
      w_load      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (con_in) begin
               if (w_cond[2] == 1'b0) begin
                  w_con_nxt  = f_eval(w_cond, w_u_cur, bus_in, bus_in);
                  w_done_nxt = 1'b1;
               end else begin
                  w_load      = 1'b1;
                  w_state_nxt = ST_WAIT_B;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_WAIT_B: begin
            if (flush) begin
               w_state_nxt = ST_IDLE;
            end else if (b_valid) begin
               w_con_nxt   = f_eval(r_cond_q, w_u_held, r_a_q, bus_in);
               w_done_nxt  = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_WAIT_B;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, decision, done pulse and operand-A capture
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         r_state   <= ST_IDLE;
         r_con_out <= 1'b0;
         r_done    <= 1'b0;
         r_cond_q  <= 3'b000;
         r_a_q     <= {WIDTH{1'b0}};
      end else begin
         r_state   <= w_state_nxt;
         r_con_out <= w_con_nxt;
         r_done    <= w_done_nxt;
         if (w_load) begin
            r_cond_q <= w_cond;
            r_a_q    <= bus_in;
         end else begin
            r_cond_q <= r_cond_q;
            r_a_q    <= r_a_q;
         end
      end
   end

   assign con_out = r_con_out;
   assign done    = r_done;
   assign busy    = (r_state == ST_WAIT_B);

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed bench for branch_cond_unit; a negedge monitor pops the expected-decision
// queue on every done pulse and flags any done with nothing expected.
module tb_branch_cond_unit;

   localparam int WIDTH    = 32;
   localparam int IR_WIDTH = 32;
   localparam int COND_LSB = 19;

   logic                clock;
   logic                clear_n;
   logic                con_in;
   logic [IR_WIDTH-1:0] ir_in;
   logic [WIDTH-1:0]    bus_in;
   logic                b_valid;
   logic                flush;
   logic                con_out;
   logic                busy;
   logic                done;

   int   checks = 0;
   int   errors = 0;
   logic exp_q[$];

   branch_cond_unit #(.WIDTH(WIDTH), .IR_WIDTH(IR_WIDTH), .COND_LSB(COND_LSB)) dut (
      .clock   (clock),
      .clear_n (clear_n),
      .con_in  (con_in),
      .ir_in   (ir_in),
      .bus_in  (bus_in),
      .b_valid (b_valid),
      .flush   (flush),
      .con_out (con_out),
      .busy    (busy),
      .done    (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: each done must match the oldest expected decision
   always @(negedge clock) begin
      if (done !== 1'b0) begin
         if (exp_q.size() == 0) begin
            chk("spurious_done", {31'd0, done}, 32'd0);
         end else begin
            chk("con_out_on_done", {31'd0, con_out}, {31'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_ir(input logic [2:0] cond, input logic u);
      logic [IR_WIDTH-1:0] ir;
      ir = $urandom;
      ir[COND_LSB +: 3] = cond;
      ir[COND_LSB+3]    = u;
      ir_in = ir;
   endtask

   task automatic single(input logic [2:0] cond, input logic [WIDTH-1:0] a, input logic exp);
      set_ir(cond, 1'b0);
      bus_in = a;
      con_in = 1'b1;
      exp_q.push_back(exp);
      step();
      con_in = 1'b0;
      chk("single_done_pulse", {31'd0, done}, 32'd1);
   endtask

   task automatic drained(input string tag);
      step();
      chk(tag, exp_q.size(), 32'd0);
   endtask

   task automatic start2(input logic [2:0] cond, input logic u, input logic [WIDTH-1:0] a);
      set_ir(cond, u);
      bus_in = a;
      con_in = 1'b1;
      step();
      con_in = 1'b0;
      set_ir(3'b000, 1'b0);
      bus_in = 32'h0000_0000;
      chk("busy_rise", {31'd0, busy}, 32'd1);
   endtask

   task automatic finish2(input logic [WIDTH-1:0] b, input logic exp);
      bus_in  = b;
      b_valid = 1'b1;
      exp_q.push_back(exp);
      step();
      b_valid = 1'b0;
      chk("busy_fall", {31'd0, busy}, 32'd0);
      chk("two_op_done", {31'd0, done}, 32'd1);
   endtask

   initial begin
      logic u_exp;
      clear_n = 1'b0;
      con_in  = 1'b1;
      ir_in   = '0;
      bus_in  = 32'h0000_0000;
      b_valid = 1'b0;
      flush   = 1'b0;

      // Reset held with con_in active
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_con_out", {31'd0, con_out}, 32'd0);
         chk("rst_busy",    {31'd0, busy},    32'd0);
         chk("rst_done",    {31'd0, done},    32'd0);
      end
      con_in  = 1'b0;
      clear_n = 1'b1;
      step();
      step();
      chk("post_rst_done", {31'd0, done}, 32'd0);

      // Single-operand conditions, back to back
      single(3'b000, 32'h0000_0000, 1'b1);
      single(3'b001, 32'h0000_0005, 1'b1);
      single(3'b000, 32'h0000_0005, 1'b0);
      single(3'b011, 32'h8000_0000, 1'b1);
      single(3'b010, 32'h8000_0000, 1'b0);
      single(3'b010, 32'h7FFF_FFFF, 1'b1);
      step();
      chk("single_done_one_cycle", {31'd0, done}, 32'd0);
      chk("singles_drained", exp_q.size(), 32'd0);

      // brlt signed: -1 < 1, busy for three cycles while ir_in changes
      start2(3'b110, 1'b0, 32'hFFFF_FFFF);
      step();
      chk("busy_wait1", {31'd0, busy}, 32'd1);
      step();
      chk("busy_wait2", {31'd0, busy}, 32'd1);
      finish2(32'h0000_0001, 1'b1);
      drained("brlt_drained");

      // brlt with unsigned-select bit set
`ifdef BRANCH_COND_UNSIGNED_EN
      u_exp = 1'b0;
`else
      u_exp = 1'b1;
`endif
      start2(3'b110, 1'b1, 32'hFFFF_FFFF);
      finish2(32'h0000_0001, u_exp);
      drained("brlt_u_drained");

      // brge equal operands, brne, breq mismatch
      start2(3'b111, 1'b0, 32'h1234_5678);
      finish2(32'h1234_5678, 1'b1);
      start2(3'b100, 1'b0, 32'h0000_0003);
      finish2(32'h0000_0004, 1'b0);
      start2(3'b101, 1'b0, 32'h0000_0003);
      finish2(32'h0000_0004, 1'b1);
      start2(3'b111, 1'b0, 32'h8000_0000);
      finish2(32'h7FFF_FFFF, 1'b0);
      start2(3'b110, 1'b0, 32'h8000_0000);
      finish2(32'h7FFF_FFFF, 1'b1);
      drained("compares_drained");

      // Flush beats simultaneous b_valid; con_out is 1 going in
      start2(3'b100, 1'b0, 32'h0000_0007);
      bus_in  = 32'h0000_0007;
      flush   = 1'b1;
      b_valid = 1'b1;
      step();
      flush   = 1'b0;
      b_valid = 1'b0;
      chk("flush_busy", {31'd0, busy}, 32'd0);
      chk("flush_done", {31'd0, done}, 32'd0);
      chk("flush_con_out_held", {31'd0, con_out}, 32'd1);
      b_valid = 1'b1;
      step();
      b_valid = 1'b0;
      step();
      chk("post_flush_bvalid_ignored", {31'd0, con_out}, 32'd1);

      // Async reset mid WAIT_B, con_out is 1 going in
      start2(3'b100, 1'b0, 32'h0000_0005);
      chk("pre_async_con_out", {31'd0, con_out}, 32'd1);
      #1;
      clear_n = 1'b0;
      #1;
      chk("async_busy", {31'd0, busy}, 32'd0);
      chk("async_con_out", {31'd0, con_out}, 32'd0);
      #1;
      clear_n = 1'b1;
      bus_in  = 32'h0000_0005;
      b_valid = 1'b1;
      step();
      b_valid = 1'b0;
      step();
      chk("post_async_con_out", {31'd0, con_out}, 32'd0);
      chk("final_drained", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_cond_unit.md
# branch_cond_unit

Parametrised branch-condition unit that succeeds the single-operand CON flip-flop in the datapath control path. It evaluates the condition field of a branch instruction against one or two operands taken from the shared bus and holds the registered branch decision `con_out` for the control unit. Single-operand conditions (zero, nonzero, plus, minus) complete in one beat. Two-operand compares (eq, ne, lt, ge) use a two-beat handshake, because only one register reaches the bus per cycle.

## Interface
- `WIDTH`, 32: bus and operand width.
- `IR_WIDTH`, 32: instruction register width.
- `COND_LSB`, 19: LSB of the 3-bit condition field `ir_in[COND_LSB+2:COND_LSB]`. The unsigned-select bit sits at `COND_LSB+3`.
- `clock` in 1: single clock; all state changes on the rising edge.
- `clear_n` in 1: asynchronous, active-low reset.
- `con_in` in 1: evaluation strobe; captures the condition field and operand A.
- `ir_in` in IR_WIDTH: instruction register contents.
- `bus_in` in WIDTH: bus value; operand A on the `con_in` beat, operand B on the `b_valid` beat.
- `b_valid` in 1: operand B is on the bus (two-operand conditions only).
- `flush` in 1: synchronous abort of a pending two-operand evaluation.
- `con_out` out 1: registered branch decision; held between evaluations.
- `busy` out 1: high while waiting for operand B.
- `done` out 1: one-cycle pulse on completion of every evaluation.

## Operation
Condition codes (cond = `ir_in[COND_LSB+2:COND_LSB]`):
- 000 brzr: A == 0.
- 001 brnz: A != 0.
- 010 brpl: A[WIDTH-1] == 0.
- 011 brmi: A[WIDTH-1] == 1.
- 100 breq: A == B.
- 101 brne: A != B.
- 110 brlt: A < B, signed.
- 111 brge: A >= B, signed.

State machine. State IDLE:
- `con_in` = 1, cond[2] = 0: update `con_out` with f(`bus_in`) and pulse `done`. Remain in IDLE.
- `con_in` = 1, cond[2] = 1: latch cond into `cond_q` and `bus_in` into `a_q`. Go to WAIT_B.
- `b_valid` and `flush` are ignored.

State WAIT_B:
- `busy` = 1.
- `con_in` is ignored; `ir_in` changes have no effect because `cond_q` is used.
- `flush` = 1: go to IDLE. `con_out` is unchanged and there is no `done`. `flush` wins over a simultaneous `b_valid`.
- `b_valid` = 1 (no flush): update `con_out` with f(`a_q`, `bus_in`) and pulse `done`. Go to IDLE.

Arithmetic rules:
- Compares use the full WIDTH.
- Signed compares treat bit WIDTH-1 as the sign bit.
- No operand is sign-extended or truncated.

## Timing
- Reset (`clear_n` low, asynchronous): state = IDLE, `con_out` = 0, `busy` = 0, `done` = 0, `a_q` = 0, `cond_q` = 0. Reset mid-WAIT_B abandons the evaluation immediately.
- Single-operand latency: `con_out` and `done` are valid in the cycle after the `con_in` edge.
- Two-operand latency: `con_out` and `done` are valid in the cycle after the `b_valid` edge. The minimum is 2 cycles from `con_in`. There is no upper bound; the unit waits indefinitely.
- `done` is registered and high for exactly one cycle per completed evaluation.
- `busy` is decoded from the state register only and is glitch-free. It rises the cycle after `con_in` and falls the cycle after `b_valid` or `flush`.
- Back-to-back: `con_in` on the cycle immediately after a `done` is accepted.
- `con_in` on the same edge that completes WAIT_B is ignored.

## Configuration
- `BRANCH_COND_UNSIGNED_EN` defined: for codes 110/111, `ir_in[COND_LSB+3]` = 1 selects an unsigned compare. The bit is latched with `cond_q`.
- Not defined: the bit is ignored and compares are always signed. No `u_q` storage is generated.

## Test plan
- Reset: drive `clear_n` = 0 with `con_in` = 1 and `bus_in` = 0 → `con_out` = 0, `busy` = 0, `done` = 0 throughout. Release → no spurious `done`.
- brzr/brnz: cond 000 with bus 0x00000000, `con_in` for 1 cycle → next cycle `con_out` = 1 and `done` = 1 for one cycle. Then cond 001 with bus 0x00000005 → `con_out` = 1. Then cond 000 with bus 0x00000005 → `con_out` = 0.
- brpl/brmi: bus 0x80000000 → cond 011 gives `con_out` = 1, cond 010 gives `con_out` = 0. Bus 0x7FFFFFFF with cond 010 → `con_out` = 1.
- brlt two-beat:
  - Cond 110, A = 0xFFFFFFFF, then `b_valid` 3 cycles later with B = 0x00000001 → `busy` = 1 for 3 cycles, then `con_out` = 1 and `done` pulses.
  - With `BRANCH_COND_UNSIGNED_EN` defined and U = 1 → `con_out` = 0.
  - Cond 111 with A = B = 0x12345678 → `con_out` = 1.
- Flush priority: `con_out` = 1 before the test. Cond 100 with A = 7, then `flush` and `b_valid` together with B = 7 → IDLE, `con_out` stays 1, no `done`. A following `b_valid` is ignored.
- Async reset mid-op: in WAIT_B with `con_out` = 1, pulse `clear_n` low between clock edges → `busy` = 0 and `con_out` = 0 immediately. A later `b_valid` produces no `done`.
